// File: rtl/cnn_frame_loader.sv
// Stream loader: filter words then ifmap words into 2-D arrays, held until cnn_done.
// Define CNN_LOADER_FILTER_REUSE_EN to keep the filter across frames after the first commit.
module cnn_frame_loader #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int IFMAP_SIZE    = 5,
    parameter int FILTER_SIZE   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IP_DATA_WIDTH-1:0] s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [IP_DATA_WIDTH-1:0] ifmap  [IFMAP_SIZE][IFMAP_SIZE],
    output logic [IP_DATA_WIDTH-1:0] filter [FILTER_SIZE][FILTER_SIZE],
    output logic                     frame_valid,
    input  logic                     cnn_done,
    output logic                     frame_err
);
    localparam int FW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int IW = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    localparam logic [FW-1:0] F_END = FW'(FILTER_SIZE - 1);
    localparam logic [IW-1:0] I_END = IW'(IFMAP_SIZE - 1);

    typedef enum logic [1:0] {LOAD_FILT, LOAD_IMG, HOLD} state_t;

    state_t                   r_state;
    logic [FW-1:0]            r_frow, r_fcol;
    logic [IW-1:0]            r_irow, r_icol;
    logic                     r_ready, r_fvalid, r_err;
    logic [IP_DATA_WIDTH-1:0] r_filter [FILTER_SIZE][FILTER_SIZE];
    logic [IP_DATA_WIDTH-1:0] r_ifmap  [IFMAP_SIZE][IFMAP_SIZE];

    logic   w_acc, w_flast, w_ilast;
    state_t w_restart;

    assign w_acc   = s_valid && r_ready;
    assign w_flast = (r_frow == F_END) && (r_fcol == F_END);
    assign w_ilast = (r_irow == I_END) && (r_icol == I_END);

`ifdef CNN_LOADER_FILTER_REUSE_EN
    // Set by the first committed frame; from then on frames carry only the image.
    logic r_keep;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_keep <= 1'b0;
        else if (r_state == LOAD_IMG && w_acc && w_ilast)
            r_keep <= 1'b1;
    end
    assign w_restart = r_keep ? LOAD_IMG : LOAD_FILT;
`else
    assign w_restart = LOAD_FILT;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= LOAD_FILT;
            r_frow   <= '0;
            r_fcol   <= '0;
            r_irow   <= '0;
            r_icol   <= '0;
            r_ready  <= 1'b1;
            r_fvalid <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < FILTER_SIZE; i++)
                for (int j = 0; j < FILTER_SIZE; j++)
                    r_filter[i][j] <= '0;
            for (int i = 0; i < IFMAP_SIZE; i++)
                for (int j = 0; j < IFMAP_SIZE; j++)
                    r_ifmap[i][j] <= '0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                LOAD_FILT: begin
                    if (w_acc) begin
                        r_filter[r_frow][r_fcol] <= s_data;
                        if (s_last) begin
                            r_err   <= 1'b1;
                            r_frow  <= '0;
                            r_fcol  <= '0;
                            r_state <= w_restart;
                        end else if (w_flast) begin
                            r_frow  <= '0;
                            r_fcol  <= '0;
                            r_state <= LOAD_IMG;
                        end else if (r_fcol == F_END) begin
                            r_fcol <= '0;
                            r_frow <= r_frow + 1'b1;
                        end else begin
                            r_fcol <= r_fcol + 1'b1;
                        end
                    end
                end
                LOAD_IMG: begin
                    if (w_acc) begin
                        r_ifmap[r_irow][r_icol] <= s_data;
                        if (w_ilast) begin
                            r_irow   <= '0;
                            r_icol   <= '0;
                            r_ready  <= 1'b0;
                            r_fvalid <= 1'b1;
                            r_err    <= !s_last;
                            r_state  <= HOLD;
                        end else if (s_last) begin
                            r_err   <= 1'b1;
                            r_irow  <= '0;
                            r_icol  <= '0;
                            r_state <= w_restart;
                        end else if (r_icol == I_END) begin
                            r_icol <= '0;
                            r_irow <= r_irow + 1'b1;
                        end else begin
                            r_icol <= r_icol + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnn_done) begin
                        r_fvalid <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= w_restart;
                    end
                end
                default: r_state <= LOAD_FILT;
            endcase
        end
    end

    assign s_ready     = r_ready;
    assign frame_valid = r_fvalid;
    assign frame_err   = r_err;
    assign filter      = r_filter;
    assign ifmap       = r_ifmap;

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Scoreboard bench for cnn_frame_loader: model frames queued at commit,
// compared when frame_valid rises.
module tb_cnn_frame_loader;
    localparam int W  = 8;
    localparam int IS = 5;
    localparam int FS = 3;
    localparam int NF = FS * FS;
    localparam int NI = IS * IS;
    localparam int NT = NF + NI;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         cnn_done = 1'b0;
    logic         s_ready, frame_valid, frame_err;
    logic [W-1:0] ifmap  [IS][IS];
    logic [W-1:0] filter [FS][FS];

    typedef struct packed {
        logic [NF-1:0][W-1:0] f;
        logic [NI-1:0][W-1:0] m;
        logic                 err;
    } frm_t;

    frm_t                 q[$];
    frm_t                 e;
    logic [NF-1:0][W-1:0] mf;
    logic [NI-1:0][W-1:0] mm;
    int                   pos = 0;
    int                   first = 0;
    int                   n_cmp = 0;
    int                   n_bad = 0;
    logic                 fv_q = 1'b0;

    cnn_frame_loader #(
        .IP_DATA_WIDTH(W),
        .IFMAP_SIZE(IS),
        .FILTER_SIZE(FS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .ifmap(ifmap),
        .filter(filter),
        .frame_valid(frame_valid),
        .cnn_done(cnn_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && frame_valid && !fv_q) begin
            if (q.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                for (int k = 0; k < NF; k++)
                    check($sformatf("filt%0d", k), 32'(filter[k/FS][k%FS]), 32'(e.f[k]));
                for (int k = 0; k < NI; k++)
                    check($sformatf("img%0d", k), 32'(ifmap[k/IS][k%IS]), 32'(e.m[k]));
                check("commit_err", 32'(frame_err), 32'(e.err));
            end
        end
        fv_q = rst ? 1'b0 : frame_valid;
    end

    function automatic logic [W-1:0] gen(input int mode, input int p);
        case (mode)
            0:       return (p < NF) ? W'(1) : W'(p - NF);
            1:       return (p < NF) ? W'(p + 50) : W'(200 - (p - NF));
            default: return W'(100 + p - NF);
        endcase
    endfunction

    function automatic int nonzero();
        int n = 0;
        for (int i = 0; i < FS; i++)
            for (int j = 0; j < FS; j++)
                if (filter[i][j] != '0) n++;
        for (int i = 0; i < IS; i++)
            for (int j = 0; j < IS; j++)
                if (ifmap[i][j] != '0) n++;
        return n;
    endfunction

    task automatic model_clear();
        mf = '0;
        mm = '0;
        pos = 0;
        first = 0;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        while (!s_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 0, 1);
            s_valid = 1'b0;
            s_last = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        if (pos < NF) mf[pos] = d;
        else mm[pos-NF] = d;
        if (pos == NT - 1) begin
            q.push_back('{f: mf, m: mm, err: !l});
`ifdef CNN_LOADER_FILTER_REUSE_EN
            first = NF;
`endif
            pos = first;
        end else if (l) begin
            pos = first;
        end else begin
            pos++;
        end
    endtask

    task automatic run(input int mode, input int from, input int to, input int lastat);
        for (int p = from; p <= to; p++)
            beat(gen(mode, p), p == lastat);
    endtask

    task automatic done();
        cnn_done = 1'b1;
        @(posedge clk);
        #1;
        cnn_done = 1'b0;
        check("done_fv", 32'(frame_valid), 0);
        check("done_rdy", 32'(s_ready), 1);
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(s_ready), 1);
        check("rst_fv", 32'(frame_valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_arr", 32'(nonzero()), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(0, 0, NT - 1, NT - 1);
        check("fv_lat", 32'(frame_valid), 1);
        check("rdy_after", 32'(s_ready), 0);
        check("err_ok", 32'(frame_err), 0);
        check("f22", 32'(filter[2][2]), 1);
        check("i23", 32'(ifmap[2][3]), 13);
        check("i44", 32'(ifmap[4][4]), 24);

`ifdef CNN_LOADER_FILTER_REUSE_EN
        done();
        run(2, NF, NT - 1, NT - 1);
        check("reuse_fv", 32'(frame_valid), 1);
        check("reuse_err", 32'(frame_err), 0);
        check("reuse_f22", 32'(filter[2][2]), 1);
        check("reuse_i00", 32'(ifmap[0][0]), 100);
        done();
        rst = 1'b1;
        #1;
        check("rst2_arr", 32'(nonzero()), 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(1, 0, NT - 1, NT - 1);
        check("full_again_fv", 32'(frame_valid), 1);
        done();
`else
        s_valid = 1'b1;
        s_data = 8'hAA;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("bp_ready", 32'(s_ready), 0);
            check("bp_i00", 32'(ifmap[0][0]), 0);
            check("bp_fv", 32'(frame_valid), 1);
        end
        done();
        beat(8'hAA, 1'b0);
        check("aa_f00", 32'(filter[0][0]), 32'hAA);

        run(1, 1, 19, 19);
        check("early_err", 32'(frame_err), 1);
        check("early_fv", 32'(frame_valid), 0);
        check("partial_i20", 32'(ifmap[2][0]), 190);
        @(posedge clk);
        #1;
        check("early_err_lo", 32'(frame_err), 0);

        run(1, 0, NT - 1, NT - 1);
        check("good_fv", 32'(frame_valid), 1);
        check("good_err", 32'(frame_err), 0);
        done();

        run(0, 0, NT - 1, -1);
        check("miss_fv", 32'(frame_valid), 1);
        check("miss_err", 32'(frame_err), 1);
        @(posedge clk);
        #1;
        check("miss_err_lo", 32'(frame_err), 0);
        done();

        run(1, 0, 14, -1);
        rst = 1'b1;
        #1;
        check("mid_rst_arr", 32'(nonzero()), 0);
        check("mid_rst_rdy", 32'(s_ready), 1);
        check("mid_rst_fv", 32'(frame_valid), 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(0, 0, NT - 1, NT - 1);
        check("after_rst_i44", 32'(ifmap[4][4]), 24);
        done();
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cnn_frame_loader.md
Name: cnn_frame_loader

Overview:
- Streaming front-end for the CNN datapath: accepts one pixel/weight per beat on a valid/ready stream.
- Assembles the filter and input image into the 2-D arrays that drive the convolution stage, then presents them as a complete frame.
- Holds the frame stable until the pipeline reports completion on its output valid (op_data_valid), then reopens for the next frame.

Parameters:
- IP_DATA_WIDTH, 8, width of each pixel/weight word
- IFMAP_SIZE, 5, input image is IFMAP_SIZE x IFMAP_SIZE
- FILTER_SIZE, 3, filter is FILTER_SIZE x FILTER_SIZE

Ports:
- clk  input  1  clock; all logic rises on posedge
- rst  input  1  asynchronous, active-high reset
- s_data  input  IP_DATA_WIDTH  stream word
- s_valid  input  1  s_data valid
- s_last  input  1  marks final word of a frame
- s_ready  output  1  loader accepts a word this cycle
- ifmap  output  [IP_DATA_WIDTH-1:0] x [IFMAP_SIZE][IFMAP_SIZE]  assembled image
- filter  output  [IP_DATA_WIDTH-1:0] x [FILTER_SIZE][FILTER_SIZE]  assembled filter
- frame_valid  output  1  ifmap/filter complete and stable
- cnn_done  input  1  completion pulse from the CNN output valid
- frame_err  output  1  one-cycle pulse on framing error

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - ifmap, filter: all zero.
  - frame_valid, frame_err: 0.
  - s_ready: 1.
  - State: LOAD_FILT; word counter: 0.
- Beat acceptance: a word is accepted when s_valid && s_ready at posedge clk.
- Frame format, row-major (index k -> row k/N, col k%N):
  - FILTER_SIZE^2 filter words first, then IFMAP_SIZE^2 ifmap words.
  - Frame length F = FILTER_SIZE^2 + IFMAP_SIZE^2 (34 by default).
- State LOAD_FILT:
  - s_ready=1; each accepted word is written to filter[k/FILTER_SIZE][k%FILTER_SIZE], counter increments.
  - After word FILTER_SIZE^2-1, counter resets to 0 and state moves to LOAD_IMG.
- State LOAD_IMG:
  - s_ready=1; each accepted word is written to ifmap[k/IFMAP_SIZE][k%IFMAP_SIZE].
  - After word IFMAP_SIZE^2-1, state moves to HOLD and frame_valid rises the next cycle (registered).
- State HOLD:
  - s_ready=0, frame_valid=1, arrays frozen.
  - On cnn_done=1: frame_valid=0 next cycle, counter=0, state moves to LOAD_FILT.
  - cnn_done is ignored outside HOLD.
- Early s_last (s_last on any accepted beat other than the final ifmap word):
  - frame_err pulses one cycle; partial frame discarded (arrays keep partially written contents, frame_valid stays 0).
  - Counter clears and state moves to LOAD_FILT.
- Missing s_last on the final ifmap word:
  - Frame still commits to HOLD; frame_err pulses one cycle, same cycle as the transition.
- Throughput and latency:
  - One word per cycle; no bubbles between filter and image phases.
  - Latency from final beat to frame_valid=1: 1 cycle.
  - s_ready is 0 in the cycle after the final beat.
- Reset mid-operation: any state returns to the reset values immediately (asynchronous); no partial frame survives.
- s_data is unsigned, stored unmodified; no arithmetic is performed.

Optional Feature:
- Macro: CNN_LOADER_FILTER_REUSE_EN
- Defined:
  - After the first committed frame, HOLD exits to LOAD_IMG instead of LOAD_FILT.
  - Subsequent frames are IFMAP_SIZE^2 words only; filter is retained.
  - Reset restores the full-frame requirement.
- Undefined: every frame carries the filter (F words).

Test Plan:
- Full frame, default params: filter words all 1, ifmap word k = k (0..24), s_last on beat 34 -> frame_valid=1 one cycle after beat 34, filter[2][2]=1, ifmap[2][3]=13, ifmap[4][4]=24, frame_err=0.
- Backpressure in HOLD: keep s_valid=1 with s_data=0xAA after commit -> s_ready=0, ifmap[0][0] stays 0 until cnn_done pulses; frame_valid falls the cycle after cnn_done; the next beat is written to filter[0][0]=0xAA.
- Early s_last on beat 20 -> frame_err high exactly one cycle, frame_valid stays 0; a following correct 34-beat frame commits normally.
- Missing s_last on beat 34 -> frame_valid=1 and frame_err=1 in the same cycle; contents correct.
- Reset mid-load: assert rst after beat 15 -> ifmap/filter all 0, s_ready=1, frame_valid=0; a new full frame loads correctly.
- Macro defined, two frames (first 34 beats, second 25 beats with ifmap word k = 100+k) -> second frame_valid after 25 beats, filter unchanged, ifmap[0][0]=100.
